// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external signed W x W multiplier among NREQ requesters.
// Optional burst lock (priority held on the granted requester) under `MUL_LOCK_EN.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 9,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W:0]      rsp_p,
  output logic              busy
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] win;
  logic           found;
  logic [IDW:0]   cand;
  logic [IDW-1:0] cand_idx;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           s1_v;
  logic [IDW-1:0] s1_id;

  // Search from ptr upward, wrapping at NREQ-1; first requester found wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      cand_idx = cand[IDW-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt   = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        gnt[i] = found && !reset;
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    if ({1'b0, win} == NREQ_W - 1'b1) ptr_nxt = '0;
    else                               ptr_nxt = win + 1'b1;
`ifdef MUL_LOCK_EN
    if (req_lock[win]) ptr_nxt = win;
`endif
  end

`ifndef MUL_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      s1_v      <= 1'b0;
      s1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      if (found) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        s1_v  <= 1'b1;
        s1_id <= win;
        ptr   <= ptr_nxt;
      end else begin
        mul_a <= '0;
        mul_b <= '0;
        s1_v  <= 1'b0;
      end
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_p  <= {mul_p[2*W-1], mul_p};
        rsp_id <= s1_id;
      end
    end
  end

  assign busy = (|req) | s1_v | rsp_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural booth multiplier.
module tb_mul_share_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [35:0] req_a;
  logic [35:0] req_b;
  logic [3:0]  req_lock;
  logic [3:0]  gnt;
  logic [8:0]  mul_a;
  logic [8:0]  mul_b;
  logic [17:0] mul_p;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [18:0] rsp_p;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [18:0] ep [4] = '{19'h0001E, 19'h7FFB0, 19'h7FF38, 19'h0015E};

  mul_share_arbiter #(.NREQ(4), .W(9), .IDW(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .req_lock(req_lock), .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy)
  );

  assign mul_p = 18'($signed(mul_a) * $signed(mul_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [8:0] a, input logic [8:0] b);
    req_a[i*9 +: 9] = a;
    req_b[i*9 +: 9] = b;
  endtask

  task automatic one_shot(input int id, input logic [8:0] a, input logic [8:0] b,
                          input logic [18:0] exp_p);
    set_op(id, a, b);
    req = 4'b0001 << id;
    #1;
    chk("os_gnt", 32'(gnt), 32'(4'b0001 << id));
    chk("os_busy", 32'(busy), 1);
    tick;
    req = 4'b0000;
    #1;
    chk("os_mul_a", 32'(mul_a), 32'(a));
    chk("os_mul_b", 32'(mul_b), 32'(b));
    chk("os_early_valid", 32'(rsp_valid), 0);
    tick;
    chk("os_valid", 32'(rsp_valid), 1);
    chk("os_id", 32'(rsp_id), 32'(id));
    chk("os_p", 32'(rsp_p), 32'(exp_p));
    tick;
    chk("os_pulse_end", 32'(rsp_valid), 0);
    chk("os_p_hold", 32'(rsp_p), 32'(exp_p));
    chk("os_idle", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; req = 4'b0001; req_lock = '0; req_a = '0; req_b = '0;
    tick;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_p", 32'(rsp_p), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    req = 4'b0000;
    #1;
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // single requests, including extreme operands
    one_shot(0, 9'h1FD, 9'd5, 19'h7FFF1);
    one_shot(1, 9'h100, 9'h100, 19'h10000);
    one_shot(2, 9'h0FF, 9'h100, 19'h70100);
    one_shot(3, 9'h100, 9'h001, 19'h7FF00);

    // all four requesting continuously from reset
    reset = 1'b1;
    tick;
    set_op(0, 9'd10, 9'd3);
    set_op(1, 9'h1EC, 9'd4);
    set_op(2, 9'd100, 9'h1FE);
    set_op(3, 9'h1F9, 9'h1CE);
    req = 4'b1111;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      if (k == 6) req = 4'b0000;
      #1;
      if (k < 6) chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      else       chk("rr_gnt_idle", 32'(gnt), 0);
      if (k >= 2) begin
        chk("rr_valid", 32'(rsp_valid), 1);
        chk("rr_id", 32'(rsp_id), 32'((k - 2) % 4));
        chk("rr_p", 32'(rsp_p), 32'(ep[(k - 2) % 4]));
      end else begin
        chk("rr_valid_lat", 32'(rsp_valid), 0);
      end
    end
    tick;
    chk("rr_drain_valid", 32'(rsp_valid), 0);
    chk("rr_drain_busy", 32'(busy), 0);

    // fairness and wrap-around
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req = 4'b0101;
    #1; chk("fair_g0", 32'(gnt), 32'h1);
    tick; #1; chk("fair_g2", 32'(gnt), 32'h4);
    tick; req = 4'b0001;
    #1; chk("fair_wrap0", 32'(gnt), 32'h1);
    tick; req = 4'b0011;
    #1; chk("fair_g1_first", 32'(gnt), 32'h2);
    tick; #1; chk("fair_then0", 32'(gnt), 32'h1);
    tick; req = 4'b0000;
    #1; chk("fair_none", 32'(gnt), 0);
    tick; tick;

    // reset one cycle after a grant discards the transaction
    reset = 1'b1;
    tick;
    reset = 1'b0;
    set_op(0, 9'd7, 9'd7);
    req = 4'b0001;
    #1; chk("mid_gnt", 32'(gnt), 32'h1);
    tick;
    req = 4'b0000;
    reset = 1'b1;
    #1;
    chk("mid_mul_a", 32'(mul_a), 0);
    chk("mid_gnt_rst", 32'(gnt), 0);
    chk("mid_busy", 32'(busy), 0);
    tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("mid_no_rsp", 32'(rsp_valid), 0);
      chk("mid_rsp_p", 32'(rsp_p), 0);
      chk("mid_rsp_id", 32'(rsp_id), 0);
      chk("mid_idle", 32'(busy), 0);
    end

    // burst lock on requester 1 (ptr brought to 1 first)
    req = 4'b0001;
    #1; chk("lk_pre", 32'(gnt), 32'h1);
    tick;
    req = 4'b0011;
    req_lock = 4'b0010;
    #1; chk("lk_g_a", 32'(gnt), 32'h2);
    tick;
    req_lock = 4'b0000;
    #1;
`ifdef MUL_LOCK_EN
    chk("lk_g_b", 32'(gnt), 32'h2);
`else
    chk("lk_g_b", 32'(gnt), 32'h1);
`endif
    tick; #1;
`ifdef MUL_LOCK_EN
    chk("lk_g_c", 32'(gnt), 32'h1);
`else
    chk("lk_g_c", 32'(gnt), 32'h2);
`endif
    tick;
    req = 4'b0000;
    tick; tick;
    chk("end_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
